execute_unit: RTL and testbench

- Execute stage of the 24-bit pipelined processor; consumes the D/E pipeline register outputs and feeds the E/M register and hazard unit.
- Contains operand forwarding muxes, the ALU, a condition check, and the architectural NZCV flags register.
- Contains an iterative shift-add multiplier that stalls the pipeline through BusyE.

---
 rtl/exec_pkg.sv | 52 +++++
 rtl/shift_add_multiplier.sv | 81 ++++++++
 rtl/execute_unit.sv | 144 ++++++++++++++
 tb/tb_execute_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage of the 24-bit pipeline.
package exec_pkg;

    localparam int unsigned DATA_W = 24;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_ORR = 3'b011,
        ALU_XOR = 3'b100,
        ALU_MUL = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        COND_AL = 2'b00,
        COND_EQ = 2'b01,
        COND_NE = 2'b10,
        COND_LT = 2'b11
    } cond_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10,
        FWD_RSV = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_t;

    // Condition evaluation against the NZCV register contents
    function automatic logic cond_pass(input cond_t cond, input logic [3:0] flags);
        case (cond)
            COND_EQ: cond_pass = flags[FLAG_Z];
            COND_NE: cond_pass = ~flags[FLAG_Z];
            COND_LT: cond_pass = flags[FLAG_N] ^ flags[FLAG_V];
            default: cond_pass = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low N product bits kept.
module shift_add_multiplier
    import exec_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product
);

    localparam int unsigned CW = $clog2(N);

    mul_state_t   state, state_nx;
    logic [N-1:0] mcand, mplier, acc;
    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    busy     = 1'b1;
                    state_nx = MUL_RUN;
                end
            end
            MUL_RUN: begin
                busy = 1'b1;
                if (count == CW'(N - 1)) state_nx = MUL_DONE;
            end
            MUL_DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch at issue, then one accumulate/shift step per MUL_RUN cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                MUL_RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign product = acc;

endmodule

// File: rtl/execute_unit.sv
// Execute stage: forwarding muxes, ALU, condition check and NZCV register.
// Define EXEC_MUL_EN to build the iterative multiplier; otherwise MUL yields 0 in one cycle.
module execute_unit
    import exec_pkg::*;
#(
    parameter int unsigned N = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         RegWriteE,
    input  logic         MemWriteE,
    input  logic         MemtoRegE,
    input  logic         BranchE,
    input  logic         PCSrcE,
    input  logic         ALUSrcE,
    input  logic [2:0]   ALUControlE,
    input  logic [1:0]   FlagWriteE,
    input  logic [1:0]   CondE,
    input  logic [N-1:0] RD1E,
    input  logic [N-1:0] RD2E,
    input  logic [N-1:0] ExtImmE,
    input  logic [1:0]   ForwardAE,
    input  logic [1:0]   ForwardBE,
    input  logic [N-1:0] ALUResultM,
    input  logic [N-1:0] ResultW,
    output logic [N-1:0] ALUResultE,
    output logic [N-1:0] WriteDataE,
    output logic         RegWriteCE,
    output logic         MemWriteCE,
    output logic         MemtoRegCE,
    output logic         PCSrcCE,
    output logic         BranchTakenE,
    output logic [3:0]   FlagsE,
    output logic         BusyE
);

    alu_op_t      alu_op;
    logic [N-1:0] src_a, src_b, alu_res, mul_product;
    logic [N:0]   add_full;
    logic [4:0]   shamt;
    logic         alu_c, alu_v, condpass, gate;
    logic         mul_busy, mul_done, cv_hold;
    logic [3:0]   flags_q, flags_d;

    function automatic logic [N-1:0] fwd_mux(input logic [1:0] sel, input logic [N-1:0] reg_val,
                                             input logic [N-1:0] w_val, input logic [N-1:0] m_val);
        case (fwd_sel_t'(sel))
            FWD_W:   fwd_mux = w_val;
            FWD_M:   fwd_mux = m_val;
            default: fwd_mux = reg_val;
        endcase
    endfunction

    assign alu_op     = alu_op_t'(ALUControlE);
    assign src_a      = fwd_mux(ForwardAE, RD1E, ResultW, ALUResultM);
    assign WriteDataE = fwd_mux(ForwardBE, RD2E, ResultW, ALUResultM);
    assign src_b      = ALUSrcE ? ExtImmE : WriteDataE;
    assign shamt      = src_b[4:0];

`ifdef EXEC_MUL_EN
    logic mul_start;

    // Start is held off during reset so BusyE reads 0 while rst is low
    assign mul_start = rst & (alu_op == ALU_MUL);
    assign cv_hold   = (alu_op == ALU_MUL);

    shift_add_multiplier #(.N(N)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (src_a),
        .b       (src_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
    assign cv_hold     = 1'b0;
`endif

    always_comb begin
        add_full = '0;
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                add_full = {1'b0, src_a} + {1'b0, src_b};
                alu_res  = add_full[N-1:0];
                alu_c    = add_full[N];
                alu_v    = (src_a[N-1] == src_b[N-1]) && (alu_res[N-1] != src_a[N-1]);
            end
            ALU_SUB: begin
                add_full = {1'b0, src_a} + {1'b0, ~src_b} + (N+1)'(1);
                alu_res  = add_full[N-1:0];
                alu_c    = add_full[N];
                alu_v    = (src_a[N-1] != src_b[N-1]) && (alu_res[N-1] != src_a[N-1]);
            end
            ALU_AND: alu_res = src_a & src_b;
            ALU_ORR: alu_res = src_a | src_b;
            ALU_XOR: alu_res = src_a ^ src_b;
            ALU_MUL: alu_res = mul_done ? mul_product : '0;
            ALU_SHL: alu_res = (32'(shamt) >= N) ? '0 : (src_a << shamt);
            ALU_SHR: alu_res = (32'(shamt) >= N) ? '0 : (src_a >> shamt);
            default: alu_res = '0;
        endcase
    end

    assign condpass = cond_pass(cond_t'(CondE), flags_q);
    assign gate     = condpass & ~mul_busy;

    // Flags never move while the multiplier holds the stage; MUL keeps C/V
    always_comb begin
        flags_d = flags_q;
        if (gate) begin
            if (FlagWriteE[1]) begin
                flags_d[FLAG_N] = alu_res[N-1];
                flags_d[FLAG_Z] = (alu_res == '0);
            end
            if (FlagWriteE[0] && !cv_hold) begin
                flags_d[FLAG_C] = alu_c;
                flags_d[FLAG_V] = alu_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flags_q <= '0;
        else      flags_q <= flags_d;
    end

    assign ALUResultE   = alu_res;
    assign RegWriteCE   = RegWriteE & gate;
    assign MemWriteCE   = MemWriteE & gate;
    assign MemtoRegCE   = MemtoRegE & gate;
    assign PCSrcCE      = PCSrcE & gate;
    assign BranchTakenE = BranchE & gate;
    assign FlagsE       = flags_q;
    assign BusyE        = mul_busy;

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit against a behavioural arithmetic/flags model.
module tb_execute_unit;

    localparam int unsigned N = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, MemtoRegE, BranchE, PCSrcE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [1:0]  FlagWriteE, CondE, ForwardAE, ForwardBE;
    logic [23:0] RD1E, RD2E, ExtImmE, ALUResultM, ResultW;
    logic [23:0] ALUResultE, WriteDataE;
    logic        RegWriteCE, MemWriteCE, MemtoRegCE, PCSrcCE, BranchTakenE, BusyE;
    logic [3:0]  FlagsE;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  exp_flags;

    execute_unit #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .BranchE(BranchE), .PCSrcE(PCSrcE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .CondE(CondE),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .RegWriteCE(RegWriteCE), .MemWriteCE(MemWriteCE), .MemtoRegCE(MemtoRegCE),
        .PCSrcCE(PCSrcCE), .BranchTakenE(BranchTakenE),
        .FlagsE(FlagsE), .BusyE(BusyE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] fwd_ref(input logic [1:0] sel, input logic [23:0] reg_val);
        if (sel == 2'd1)      return ResultW;
        else if (sel == 2'd2) return ALUResultM;
        else                  return reg_val;
    endfunction

    // Returns {C, V, result} from plain integer arithmetic
    function automatic logic [25:0] ref_alu(input logic [2:0] op, input logic [23:0] a, input logic [23:0] b);
        longint      ua, ub, sa, sb, t;
        logic [23:0] r;
        logic        c, v;
        int          sh;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[23] ? ua - 64'h1000000 : ua;
        sb = b[23] ? ub - 64'h1000000 : ub;
        sh = int'(b[4:0]);
        c  = 1'b0;
        v  = 1'b0;
        r  = '0;
        case (op)
            3'd0: begin
                t = ua + ub; r = 24'(t); c = (t >= 64'h1000000);
                t = sa + sb; v = (t > 8388607) || (t < -8388608);
            end
            3'd1: begin
                t = ua - ub; r = 24'(t); c = (ua >= ub);
                t = sa - sb; v = (t > 8388607) || (t < -8388608);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
`ifdef EXEC_MUL_EN
            3'd5: r = 24'(ua * ub);
`else
            3'd5: r = '0;
`endif
            3'd6: r = (sh >= 24) ? 24'd0 : 24'(ua << sh);
            default: r = (sh >= 24) ? 24'd0 : 24'(ua >> sh);
        endcase
        return {c, v, r};
    endfunction

    function automatic logic cond_ok(input logic [1:0] cond, input logic [3:0] f);
        case (cond)
            2'd1:    return f[2];
            2'd2:    return !f[2];
            2'd3:    return f[3] != f[0];
            default: return 1'b1;
        endcase
    endfunction

    // One single-cycle instruction: called at posedge+1, returns at the next posedge+1
    task automatic run_op(input string tag, input logic [2:0] op, input logic [23:0] rd1, input logic [23:0] rd2,
                          input logic [23:0] imm, input logic [1:0] fa, input logic [1:0] fb, input logic alusrc,
                          input logic [1:0] fw, input logic [1:0] cond, input logic bra);
        logic [23:0] sa, wd, sb;
        logic [25:0] m;
        logic        pass;
        ALUControlE = op; RD1E = rd1; RD2E = rd2; ExtImmE = imm;
        ForwardAE = fa; ForwardBE = fb; ALUSrcE = alusrc; FlagWriteE = fw; CondE = cond;
        RegWriteE = 1'b1; MemWriteE = 1'b1; MemtoRegE = 1'b1; BranchE = bra; PCSrcE = bra;
        sa   = fwd_ref(fa, rd1);
        wd   = fwd_ref(fb, rd2);
        sb   = alusrc ? imm : wd;
        m    = ref_alu(op, sa, sb);
        pass = cond_ok(cond, exp_flags);
        @(negedge clk);
        check({tag, ".result"}, 32'(ALUResultE), 32'(m[23:0]));
        check({tag, ".wdata"}, 32'(WriteDataE), 32'(wd));
        check({tag, ".regw"}, 32'(RegWriteCE), 32'(pass));
        check({tag, ".branch"}, 32'(BranchTakenE), 32'(bra & pass));
        check({tag, ".busy"}, 32'(BusyE), 32'(0));
        @(posedge clk); #1;
        if (pass) begin
            if (fw[1]) begin exp_flags[3] = m[23]; exp_flags[2] = (m[23:0] == 24'd0); end
            if (fw[0]) begin exp_flags[1] = m[25]; exp_flags[0] = m[24]; end
        end
        check({tag, ".flags"}, 32'(FlagsE), 32'(exp_flags));
    endtask

`ifdef EXEC_MUL_EN
    // Multiply with the multiplicand forwarded from ResultW, which is scrambled after issue
    task automatic mul_op(input string tag, input logic [23:0] a, input logic [23:0] b, input logic [1:0] fw);
        logic [25:0] m;
        logic [3:0]  flags0;
        int          busy_cnt;
        logic        ok_gate, ok_flags;
        ALUControlE = 3'd5; RD1E = 24'(~a); ResultW = a; ForwardAE = 2'd1;
        ExtImmE = b; ALUSrcE = 1'b1; ForwardBE = 2'd0; FlagWriteE = fw; CondE = 2'd0;
        RegWriteE = 1'b1; MemWriteE = 1'b0; MemtoRegE = 1'b0; BranchE = 1'b0; PCSrcE = 1'b0;
        m = ref_alu(3'd5, a, b);
        flags0 = exp_flags; busy_cnt = 0; ok_gate = 1'b1; ok_flags = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!BusyE) break;
            busy_cnt++;
            if (RegWriteCE !== 1'b0) ok_gate = 1'b0;
            @(posedge clk); #1;
            if (FlagsE !== flags0) ok_flags = 1'b0;
            ResultW = 24'($urandom);
            ALUResultM = 24'($urandom);
        end
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(25));
        check({tag, ".gated_while_busy"}, 32'(ok_gate), 32'(1));
        check({tag, ".flags_held"}, 32'(ok_flags), 32'(1));
        check({tag, ".product"}, 32'(ALUResultE), 32'(m[23:0]));
        check({tag, ".regw_done"}, 32'(RegWriteCE), 32'(1));
        @(posedge clk); #1;
        if (fw[1]) begin exp_flags[3] = m[23]; exp_flags[2] = (m[23:0] == 24'd0); end
        check({tag, ".flags"}, 32'(FlagsE), 32'(exp_flags));
    endtask
`endif

    initial begin
        logic [2:0] op;
        rst = 1'b0;
        RegWriteE = 1'b0; MemWriteE = 1'b0; MemtoRegE = 1'b0; BranchE = 1'b0; PCSrcE = 1'b0;
        ALUSrcE = 1'b0; ALUControlE = 3'd0; FlagWriteE = 2'd0; CondE = 2'd0;
        RD1E = '0; RD2E = '0; ExtImmE = '0; ForwardAE = 2'd0; ForwardBE = 2'd0;
        ALUResultM = '0; ResultW = '0;
        exp_flags = 4'd0;
        #2;
        check("reset.busy", 32'(BusyE), 32'(0));
        check("reset.flags", 32'(FlagsE), 32'(0));
        check("reset.result", 32'(ALUResultE), 32'(0));
        #1 rst = 1'b1;
        @(posedge clk); #1;

        run_op("add_ovf", 3'd0, 24'h7FFFFF, 24'h0, 24'h000001, 2'd0, 2'd0, 1'b1, 2'b11, 2'd0, 1'b0);
        check("add_ovf.nzcv", 32'(FlagsE), 32'(4'b1001));
        run_op("sub_zero", 3'd1, 24'd5, 24'd5, 24'd0, 2'd0, 2'd0, 1'b0, 2'b11, 2'd0, 1'b0);
        check("sub_zero.nzcv", 32'(FlagsE), 32'(4'b0110));
        run_op("beq", 3'd0, 24'd0, 24'd0, 24'd0, 2'd0, 2'd0, 1'b1, 2'b00, 2'd1, 1'b1);
        run_op("bne", 3'd0, 24'd0, 24'd0, 24'd0, 2'd0, 2'd0, 1'b1, 2'b00, 2'd2, 1'b1);
        ALUResultM = 24'h000010;
        run_op("fwd_m", 3'd0, 24'd1, 24'd0, 24'd2, 2'd2, 2'd0, 1'b1, 2'b00, 2'd0, 1'b0);
        check("fwd_m.value", 32'(ALUResultE), 32'(24'h000012));

`ifdef EXEC_MUL_EN
        mul_op("mul_123x10", 24'h000123, 24'h000010, 2'b11);
        // Abort a multiply at count 10 with an asynchronous reset
        ALUControlE = 3'd5; RD1E = 24'h000123; ForwardAE = 2'd0; ExtImmE = 24'h10; ALUSrcE = 1'b1;
        FlagWriteE = 2'b11; CondE = 2'd0;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort.busy", 32'(BusyE), 32'(0));
        check("abort.flags", 32'(FlagsE), 32'(0));
        exp_flags = 4'd0;
        @(posedge clk); #1 rst = 1'b1;
        mul_op("mul_3x4", 24'd3, 24'd4, 2'b11);
`else
        run_op("mul_off", 3'd5, 24'h000123, 24'd0, 24'h000010, 2'd0, 2'd0, 1'b1, 2'b11, 2'd0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("abort.busy", 32'(BusyE), 32'(0));
        check("abort.flags", 32'(FlagsE), 32'(0));
        exp_flags = 4'd0;
        @(posedge clk); #1 rst = 1'b1;
        run_op("mul_3x4_off", 3'd5, 24'd3, 24'd4, 24'd0, 2'd0, 2'd0, 1'b0, 2'b11, 2'd0, 1'b0);
`endif

        run_op("shl24", 3'd6, 24'h000001, 24'd0, 24'd24, 2'd0, 2'd0, 1'b1, 2'b11, 2'd0, 1'b0);
        check("shl24.z", 32'(FlagsE[2]), 32'(1));
        run_op("shr23", 3'd7, 24'h800000, 24'd0, 24'd23, 2'd0, 2'd0, 1'b1, 2'b11, 2'd0, 1'b0);
        check("shr23.value", 32'(ALUResultE), 32'(24'h000001));

        for (int i = 0; i < 40; i++) begin
            logic [23:0] r1, r2, im;
            op = 3'($urandom_range(0, 7));
`ifdef EXEC_MUL_EN
            if (op == 3'd5) op = 3'd1;
`endif
            ResultW    = 24'($urandom);
            ALUResultM = 24'($urandom);
            r1 = 24'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 24'($urandom);
            im = ($urandom_range(0, 1) == 1) ? 24'($urandom_range(0, 31)) : 24'($urandom);
            run_op("rand", op, r1, r2, im, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
